// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical position counters with registered sync,
// visible-area and frame-start strobes aligned to the DrawX/DrawY of the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(HT - 1);
  localparam logic [9:0] V_MAX      = 10'(VT - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  // Wrap is detected on the terminal value, so neither counter ever reaches HT/VT.
  always_comb begin
    h_wrap = (DrawX == H_MAX);
    v_wrap = (DrawY == V_MAX);
    h_next = h_wrap ? 10'd0 : DrawX + 10'd1;
    v_next = DrawY;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Strobes decode the next position so they line up with the registered counters.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      DrawX       <= h_next;
      DrawY       <= v_next;
      hs          <= !((h_next >= HS_START) && (h_next < HS_END));
      vs          <= !((v_next >= VS_START) && (v_next < VS_END));
      blank       <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a
// shrunken-timing instance for frame, wrap and mid-frame reset behaviour.
module tb_vga_timing_gen;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHV + SHF + SHS + SHB;   // 15
  localparam int SVT = SVV + SVF + SVS + SVB;   // 10

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;

  logic       s_hs, s_vs, s_blank, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;
  logic       d_hs, d_vs, d_blank, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  int total = 0;
  int bad   = 0;

  int mx = 0, my = 0, mfc = 0, mfs = 0;
  int dx = 0, dy = 0;
  bit chk_def = 1'b0;
  int fs_pulses = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset(reset), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .frame_count(d_fc)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== 32'(exp)) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the reference positions, then compare just after the edge.
  task automatic tick();
    bit rst_s;
    bit wrap;
    @(posedge vga_clk);
    rst_s = reset;
    if (rst_s) begin
      mx = 0; my = 0; mfc = 0; mfs = 0; dx = 0; dy = 0;
    end else begin
      wrap = (mx == SHT - 1) && (my == SVT - 1);
      if (mx == SHT - 1) begin
        mx = 0;
        my = (my == SVT - 1) ? 0 : my + 1;
      end else mx++;
      if (wrap) mfc = (mfc + 1) % 256;
      mfs = (mx == 0 && my == 0) ? 1 : 0;
      if (dx == 799) begin
        dx = 0;
        dy = (dy == 524) ? 0 : dy + 1;
      end else dx++;
    end
    #1;
    check_val("s_x", s_x, mx);
    check_val("s_y", s_y, my);
    check_val("s_hs", s_hs, (mx >= 10 && mx < 13) ? 0 : 1);
    check_val("s_vs", s_vs, (my >= 7 && my < 9) ? 0 : 1);
    check_val("s_blank", s_blank, (mx < 8 && my < 6) ? 1 : 0);
    check_val("s_fs", s_fs, mfs);
    check_val("s_fc", s_fc, mfc);
    check_val("s_bounds", (s_x < 10'(SHT)) && (s_y < 10'(SVT)), 1);
    if (chk_def) begin
      check_val("d_x", d_x, dx);
      check_val("d_y", d_y, dy);
      check_val("d_hs", d_hs, (dx >= 656 && dx < 752) ? 0 : 1);
      check_val("d_vs", d_vs, (dy >= 490 && dy < 492) ? 0 : 1);
      check_val("d_blank", d_blank, (dx < 640 && dy < 480) ? 1 : 0);
      check_val("d_bounds", (d_x < 10'd800) && (d_y < 10'd525), 1);
    end
    if (s_fs === 1'b1) fs_pulses++;
  endtask

  initial begin
    int hs_low, blank_fall_x, wrap_y, vs_low, first_fs, n;
    logic [9:0] prev_dx;

    chk_def = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check_val("rst_d_fs", d_fs, 0);
    check_val("rst_d_fc", d_fc, 0);
    reset = 1'b0;

    hs_low = 0; blank_fall_x = -1; wrap_y = -1; prev_dx = d_x;
    for (int i = 0; i < 810; i++) begin
      tick();
      if (d_hs === 1'b0 && d_y == 10'd0) hs_low++;
      if (blank_fall_x < 0 && d_blank === 1'b0) blank_fall_x = int'(d_x);
      if (prev_dx == 10'd799 && d_x == 10'd0) wrap_y = int'(d_y);
      prev_dx = d_x;
    end
    check_val("def_hs_low_len", hs_low, 96);
    check_val("def_blank_fall_x", blank_fall_x, 640);
    check_val("def_wrap_y", wrap_y, 1);
    chk_def = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    fs_pulses = 0;
    vs_low = 0; first_fs = -1;
    for (int i = 1; i <= SHT * SVT; i++) begin
      tick();
      if (s_vs === 1'b0) vs_low++;
      if (first_fs < 0 && s_fs === 1'b1) first_fs = i;
    end
    check_val("first_fs_delay", first_fs, SHT * SVT);
    check_val("frame1_vs_low", vs_low, SVS * SHT);
    check_val("frame1_fc", s_fc, 1);
    for (int f = 2; f <= 256; f++) begin
      repeat (SHT * SVT) tick();
      check_val("frame_fs_at_end", s_fs, 1);
    end
    check_val("fc_wrap_256", s_fc, 0);
    check_val("fs_pulses_256", fs_pulses, 256);

    n = 0;
    while (!(s_x == 10'd10 && s_y == 10'd5) && n < 200) begin
      tick();
      n++;
    end
    check_val("reach_mid_frame", n < 200, 1);
    check_val("mid_hs_low", s_hs, 0);
    reset = 1'b1;
    tick();
    check_val("midrst_x", s_x, 0);
    check_val("midrst_y", s_y, 0);
    check_val("midrst_hs", s_hs, 1);
    check_val("midrst_vs", s_vs, 1);
    check_val("midrst_blank", s_blank, 1);
    check_val("midrst_fs", s_fs, 0);
    check_val("midrst_fc", s_fc, 0);
    reset = 1'b0;
    tick();
    check_val("post_rst_x", s_x, 1);
    repeat (SHT * SVT - 1) tick();
    check_val("post_rst_fs", s_fs, 1);
    check_val("post_rst_fc", s_fc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
